// File: rtl/ysyx_24090012_xbar.sv
// Two-target AXI4 crossbar: routes each transaction from the arbiter to the CLINT or the SoC bus.
// Define XBAR_CLINT_EN to enable the CLINT target; otherwise every address goes to the SoC.
module ysyx_24090012_xbar #(
    parameter logic [31:0] CLINT_BASE = 32'h0200_0000,
    parameter logic [31:0] CLINT_MASK = 32'hFFFF_0000
) (
    input  logic        clk,
    input  logic        rst,
    // upstream (arbiter) port
    input  logic        in_awvalid,
    output logic        in_awready,
    input  logic [31:0] in_awaddr,
    input  logic [3:0]  in_awid,
    input  logic [7:0]  in_awlen,
    input  logic [2:0]  in_awsize,
    input  logic [1:0]  in_awburst,
    input  logic        in_wvalid,
    output logic        in_wready,
    input  logic [31:0] in_wdata,
    input  logic [3:0]  in_wstrb,
    input  logic        in_wlast,
    input  logic        in_bready,
    output logic        in_bvalid,
    output logic [1:0]  in_bresp,
    output logic [3:0]  in_bid,
    input  logic        in_arvalid,
    output logic        in_arready,
    input  logic [31:0] in_araddr,
    input  logic [3:0]  in_arid,
    input  logic [7:0]  in_arlen,
    input  logic [2:0]  in_arsize,
    input  logic [1:0]  in_arburst,
    input  logic        in_rready,
    output logic        in_rvalid,
    output logic [1:0]  in_rresp,
    output logic [31:0] in_rdata,
    output logic        in_rlast,
    output logic [3:0]  in_rid,
    // SoC master port
    output logic        soc_awvalid,
    input  logic        soc_awready,
    output logic [31:0] soc_awaddr,
    output logic [3:0]  soc_awid,
    output logic [7:0]  soc_awlen,
    output logic [2:0]  soc_awsize,
    output logic [1:0]  soc_awburst,
    output logic        soc_wvalid,
    input  logic        soc_wready,
    output logic [31:0] soc_wdata,
    output logic [3:0]  soc_wstrb,
    output logic        soc_wlast,
    output logic        soc_bready,
    input  logic        soc_bvalid,
    input  logic [1:0]  soc_bresp,
    input  logic [3:0]  soc_bid,
    output logic        soc_arvalid,
    input  logic        soc_arready,
    output logic [31:0] soc_araddr,
    output logic [3:0]  soc_arid,
    output logic [7:0]  soc_arlen,
    output logic [2:0]  soc_arsize,
    output logic [1:0]  soc_arburst,
    output logic        soc_rready,
    input  logic        soc_rvalid,
    input  logic [1:0]  soc_rresp,
    input  logic [31:0] soc_rdata,
    input  logic        soc_rlast,
    input  logic [3:0]  soc_rid,
    // CLINT master port
    output logic        clint_awvalid,
    input  logic        clint_awready,
    output logic [31:0] clint_awaddr,
    output logic [3:0]  clint_awid,
    output logic [7:0]  clint_awlen,
    output logic [2:0]  clint_awsize,
    output logic [1:0]  clint_awburst,
    output logic        clint_wvalid,
    input  logic        clint_wready,
    output logic [31:0] clint_wdata,
    output logic [3:0]  clint_wstrb,
    output logic        clint_wlast,
    output logic        clint_bready,
    input  logic        clint_bvalid,
    input  logic [1:0]  clint_bresp,
    input  logic [3:0]  clint_bid,
    output logic        clint_arvalid,
    input  logic        clint_arready,
    output logic [31:0] clint_araddr,
    output logic [3:0]  clint_arid,
    output logic [7:0]  clint_arlen,
    output logic [2:0]  clint_arsize,
    output logic [1:0]  clint_arburst,
    output logic        clint_rready,
    input  logic        clint_rvalid,
    input  logic [1:0]  clint_rresp,
    input  logic [31:0] clint_rdata,
    input  logic        clint_rlast,
    input  logic [3:0]  clint_rid
);

`ifdef XBAR_CLINT_EN
    localparam logic CLINT_EN = 1'b1;
`else
    localparam logic CLINT_EN = 1'b0;
`endif

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] WR_SOC   = 3'd1;
    localparam logic [2:0] WR_CLINT = 3'd2;
    localparam logic [2:0] RD_SOC   = 3'd3;
    localparam logic [2:0] RD_CLINT = 3'd4;

    logic [2:0] state;
    logic [2:0] state_nxt;
    logic       aw_hit, ar_hit;
    logic       wr_soc, wr_clint, rd_soc, rd_clint;

    assign aw_hit = CLINT_EN && ((in_awaddr & CLINT_MASK) == CLINT_BASE);
    assign ar_hit = CLINT_EN && ((in_araddr & CLINT_MASK) == CLINT_BASE);

    always_comb begin
        // NOTE: defaulting to the current state gives every path an assignment, so no latch is inferred.
        state_nxt = state;
        case (state)
            IDLE: begin
                if (in_awvalid)      state_nxt = aw_hit ? WR_CLINT : WR_SOC;
                else if (in_arvalid) state_nxt = ar_hit ? RD_CLINT : RD_SOC;
            end
            WR_SOC:   if (soc_bvalid && in_bready)                state_nxt = IDLE;
            WR_CLINT: if (clint_bvalid && in_bready)              state_nxt = IDLE;
            RD_SOC:   if (soc_rvalid && in_rready && soc_rlast)   state_nxt = IDLE;
            RD_CLINT: if (clint_rvalid && in_rready && clint_rlast) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // NOTE: registered state uses non-blocking assignment so every reader sees the pre-edge value.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // CLINT routes are forced off when the target is compiled out, tying clint_* outputs low.
    assign wr_soc   = (state == WR_SOC);
    assign rd_soc   = (state == RD_SOC);
    assign wr_clint = CLINT_EN && (state == WR_CLINT);
    assign rd_clint = CLINT_EN && (state == RD_CLINT);

    assign soc_awvalid   = wr_soc & in_awvalid;
    assign soc_awaddr    = wr_soc ? in_awaddr  : '0;
    assign soc_awid      = wr_soc ? in_awid    : '0;
    assign soc_awlen     = wr_soc ? in_awlen   : '0;
    assign soc_awsize    = wr_soc ? in_awsize  : '0;
    assign soc_awburst   = wr_soc ? in_awburst : '0;
    assign soc_wvalid    = wr_soc & in_wvalid;
    assign soc_wdata     = wr_soc ? in_wdata   : '0;
    assign soc_wstrb     = wr_soc ? in_wstrb   : '0;
    assign soc_wlast     = wr_soc & in_wlast;
    assign soc_bready    = wr_soc & in_bready;
    assign soc_arvalid   = rd_soc & in_arvalid;
    assign soc_araddr    = rd_soc ? in_araddr  : '0;
    assign soc_arid      = rd_soc ? in_arid    : '0;
    assign soc_arlen     = rd_soc ? in_arlen   : '0;
    assign soc_arsize    = rd_soc ? in_arsize  : '0;
    assign soc_arburst   = rd_soc ? in_arburst : '0;
    assign soc_rready    = rd_soc & in_rready;

    assign clint_awvalid = wr_clint & in_awvalid;
    assign clint_awaddr  = wr_clint ? in_awaddr  : '0;
    assign clint_awid    = wr_clint ? in_awid    : '0;
    assign clint_awlen   = wr_clint ? in_awlen   : '0;
    assign clint_awsize  = wr_clint ? in_awsize  : '0;
    assign clint_awburst = wr_clint ? in_awburst : '0;
    assign clint_wvalid  = wr_clint & in_wvalid;
    assign clint_wdata   = wr_clint ? in_wdata   : '0;
    assign clint_wstrb   = wr_clint ? in_wstrb   : '0;
    assign clint_wlast   = wr_clint & in_wlast;
    assign clint_bready  = wr_clint & in_bready;
    assign clint_arvalid = rd_clint & in_arvalid;
    assign clint_araddr  = rd_clint ? in_araddr  : '0;
    assign clint_arid    = rd_clint ? in_arid    : '0;
    assign clint_arlen   = rd_clint ? in_arlen   : '0;
    assign clint_arsize  = rd_clint ? in_arsize  : '0;
    assign clint_arburst = rd_clint ? in_arburst : '0;
    assign clint_rready  = rd_clint & in_rready;

    assign in_awready = (wr_soc & soc_awready) | (wr_clint & clint_awready);
    assign in_wready  = (wr_soc & soc_wready)  | (wr_clint & clint_wready);
    assign in_bvalid  = (wr_soc & soc_bvalid)  | (wr_clint & clint_bvalid);
    assign in_bresp   = wr_soc ? soc_bresp : (wr_clint ? clint_bresp : '0);
    assign in_bid     = wr_soc ? soc_bid   : (wr_clint ? clint_bid   : '0);
    assign in_arready = (rd_soc & soc_arready) | (rd_clint & clint_arready);
    assign in_rvalid  = (rd_soc & soc_rvalid)  | (rd_clint & clint_rvalid);
    assign in_rresp   = rd_soc ? soc_rresp : (rd_clint ? clint_rresp : '0);
    assign in_rdata   = rd_soc ? soc_rdata : (rd_clint ? clint_rdata : '0);
    assign in_rlast   = (rd_soc & soc_rlast)   | (rd_clint & clint_rlast);
    assign in_rid     = rd_soc ? soc_rid   : (rd_clint ? clint_rid   : '0);

endmodule

// File: tb/tb_ysyx_24090012_xbar.sv
// Self-checking bench for ysyx_24090012_xbar: the bench plays the arbiter and both slaves,
// predicting the routed target from the address decode rule and checking each phase of every transaction.
module tb_ysyx_24090012_xbar;

    localparam logic [31:0] CLINT_BASE = 32'h0200_0000;
    localparam logic [31:0] CLINT_MASK = 32'hFFFF_0000;
`ifdef XBAR_CLINT_EN
    localparam logic CLINT_ON = 1'b1;
`else
    localparam logic CLINT_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic        in_awvalid, in_awready, in_wvalid, in_wready, in_wlast, in_bready, in_bvalid;
    logic [31:0] in_awaddr, in_wdata, in_araddr, in_rdata;
    logic [3:0]  in_awid, in_wstrb, in_bid, in_arid, in_rid;
    logic [7:0]  in_awlen, in_arlen;
    logic [2:0]  in_awsize, in_arsize;
    logic [1:0]  in_awburst, in_bresp, in_arburst, in_rresp;
    logic        in_arvalid, in_arready, in_rready, in_rvalid, in_rlast;

    logic        soc_awvalid, soc_awready, soc_wvalid, soc_wready, soc_wlast, soc_bready, soc_bvalid;
    logic [31:0] soc_awaddr, soc_wdata, soc_araddr, soc_rdata;
    logic [3:0]  soc_awid, soc_wstrb, soc_bid, soc_arid, soc_rid;
    logic [7:0]  soc_awlen, soc_arlen;
    logic [2:0]  soc_awsize, soc_arsize;
    logic [1:0]  soc_awburst, soc_bresp, soc_arburst, soc_rresp;
    logic        soc_arvalid, soc_arready, soc_rready, soc_rvalid, soc_rlast;

    logic        clint_awvalid, clint_awready, clint_wvalid, clint_wready, clint_wlast, clint_bready, clint_bvalid;
    logic [31:0] clint_awaddr, clint_wdata, clint_araddr, clint_rdata;
    logic [3:0]  clint_awid, clint_wstrb, clint_bid, clint_arid, clint_rid;
    logic [7:0]  clint_awlen, clint_arlen;
    logic [2:0]  clint_awsize, clint_arsize;
    logic [1:0]  clint_awburst, clint_bresp, clint_arburst, clint_rresp;
    logic        clint_arvalid, clint_arready, clint_rready, clint_rvalid, clint_rlast;

    logic [14:0] hs_all;
    assign hs_all = {in_awready, in_wready, in_bvalid, in_arready, in_rvalid,
                     soc_awvalid, soc_wvalid, soc_bready, soc_arvalid, soc_rready,
                     clint_awvalid, clint_wvalid, clint_bready, clint_arvalid, clint_rready};

    ysyx_24090012_xbar #(.CLINT_BASE(CLINT_BASE), .CLINT_MASK(CLINT_MASK)) dut (
        .clk(clk), .rst(rst),
        .in_awvalid(in_awvalid), .in_awready(in_awready), .in_awaddr(in_awaddr), .in_awid(in_awid),
        .in_awlen(in_awlen), .in_awsize(in_awsize), .in_awburst(in_awburst),
        .in_wvalid(in_wvalid), .in_wready(in_wready), .in_wdata(in_wdata), .in_wstrb(in_wstrb), .in_wlast(in_wlast),
        .in_bready(in_bready), .in_bvalid(in_bvalid), .in_bresp(in_bresp), .in_bid(in_bid),
        .in_arvalid(in_arvalid), .in_arready(in_arready), .in_araddr(in_araddr), .in_arid(in_arid),
        .in_arlen(in_arlen), .in_arsize(in_arsize), .in_arburst(in_arburst),
        .in_rready(in_rready), .in_rvalid(in_rvalid), .in_rresp(in_rresp), .in_rdata(in_rdata),
        .in_rlast(in_rlast), .in_rid(in_rid),
        .soc_awvalid(soc_awvalid), .soc_awready(soc_awready), .soc_awaddr(soc_awaddr), .soc_awid(soc_awid),
        .soc_awlen(soc_awlen), .soc_awsize(soc_awsize), .soc_awburst(soc_awburst),
        .soc_wvalid(soc_wvalid), .soc_wready(soc_wready), .soc_wdata(soc_wdata), .soc_wstrb(soc_wstrb), .soc_wlast(soc_wlast),
        .soc_bready(soc_bready), .soc_bvalid(soc_bvalid), .soc_bresp(soc_bresp), .soc_bid(soc_bid),
        .soc_arvalid(soc_arvalid), .soc_arready(soc_arready), .soc_araddr(soc_araddr), .soc_arid(soc_arid),
        .soc_arlen(soc_arlen), .soc_arsize(soc_arsize), .soc_arburst(soc_arburst),
        .soc_rready(soc_rready), .soc_rvalid(soc_rvalid), .soc_rresp(soc_rresp), .soc_rdata(soc_rdata),
        .soc_rlast(soc_rlast), .soc_rid(soc_rid),
        .clint_awvalid(clint_awvalid), .clint_awready(clint_awready), .clint_awaddr(clint_awaddr), .clint_awid(clint_awid),
        .clint_awlen(clint_awlen), .clint_awsize(clint_awsize), .clint_awburst(clint_awburst),
        .clint_wvalid(clint_wvalid), .clint_wready(clint_wready), .clint_wdata(clint_wdata), .clint_wstrb(clint_wstrb),
        .clint_wlast(clint_wlast),
        .clint_bready(clint_bready), .clint_bvalid(clint_bvalid), .clint_bresp(clint_bresp), .clint_bid(clint_bid),
        .clint_arvalid(clint_arvalid), .clint_arready(clint_arready), .clint_araddr(clint_araddr), .clint_arid(clint_arid),
        .clint_arlen(clint_arlen), .clint_arsize(clint_arsize), .clint_arburst(clint_arburst),
        .clint_rready(clint_rready), .clint_rvalid(clint_rvalid), .clint_rresp(clint_rresp), .clint_rdata(clint_rdata),
        .clint_rlast(clint_rlast), .clint_rid(clint_rid)
    );

    // Reference decode: which target the whole transaction must land on.
    function automatic logic exp_clint(input logic [31:0] a);
        return CLINT_ON && ((a & CLINT_MASK) == CLINT_BASE);
    endfunction

    task automatic clear_write();
        in_awvalid = 0; in_awaddr = 0; in_awid = 0; in_awlen = 0; in_awsize = 0; in_awburst = 0;
        in_wvalid = 0; in_wdata = 0; in_wstrb = 0; in_wlast = 0; in_bready = 0;
        soc_awready = 0; soc_wready = 0; soc_bvalid = 0; soc_bresp = 0; soc_bid = 0;
        clint_awready = 0; clint_wready = 0; clint_bvalid = 0; clint_bresp = 0; clint_bid = 0;
    endtask

    task automatic clear_read();
        in_arvalid = 0; in_araddr = 0; in_arid = 0; in_arlen = 0; in_arsize = 0; in_arburst = 0; in_rready = 0;
        soc_arready = 0; soc_rvalid = 0; soc_rresp = 0; soc_rdata = 0; soc_rlast = 0; soc_rid = 0;
        clint_arready = 0; clint_rvalid = 0; clint_rresp = 0; clint_rdata = 0; clint_rlast = 0; clint_rid = 0;
    endtask

    // Tasks start and end just after a rising edge; outputs are sampled on the falling edge.
    task automatic do_read(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                           input int stall, input logic [31:0] first);
        logic c;
        logic last;
        logic [31:0] td [0:3];
        c = exp_clint(addr);
        for (int i = 0; i < 4; i++) td[i] = (i == 0) ? first : $urandom;
        in_arvalid = 1; in_araddr = addr; in_arid = id; in_arlen = len; in_arsize = 3'd2; in_arburst = 2'b01;
        soc_arready = 1; clint_arready = 1;
        @(negedge clk);
        n_checks++;
        if ({soc_arvalid, clint_arvalid, in_arready} !== 3'b000) begin
            n_fail++;
            $display("FAIL rd_decode_cycle addr=%h: got soc/clint arvalid,arready=%b%b%b, expected 000",
                     addr, soc_arvalid, clint_arvalid, in_arready);
        end
        @(posedge clk); #1;
        @(negedge clk);
        n_checks++;
        if ({c ? clint_arvalid : soc_arvalid, c ? soc_arvalid : clint_arvalid, in_arready,
             c ? clint_araddr : soc_araddr, c ? clint_arid : soc_arid, c ? clint_arlen : soc_arlen,
             c ? clint_arsize : soc_arsize, c ? clint_arburst : soc_arburst} !==
            {3'b101, addr, id, len, 3'd2, 2'b01}) begin
            n_fail++;
            $display("FAIL rd_ar_forward addr=%h to_clint=%b: got soc_arvalid=%b clint_arvalid=%b arready=%b soc_araddr=%h clint_araddr=%h",
                     addr, c, soc_arvalid, clint_arvalid, in_arready, soc_araddr, clint_araddr);
        end
        @(posedge clk); #1;
        in_arvalid = 0; soc_arready = 0; clint_arready = 0;
        for (int b = 0; b <= int'(len); b++) begin
            last = (b == int'(len));
            soc_rvalid = 1; clint_rvalid = 1; soc_rlast = last; clint_rlast = last;
            soc_rdata = c ? ~td[b] : td[b]; clint_rdata = c ? td[b] : ~td[b];
            soc_rid = id; clint_rid = ~id; soc_rresp = c ? 2'b10 : 2'b00; clint_rresp = c ? 2'b00 : 2'b10;
            if (b == stall) begin
                in_rready = 0;
                @(negedge clk);
                n_checks++;
                if ({in_rvalid, in_rdata, c ? clint_rready : soc_rready} !== {1'b1, td[b], 1'b0}) begin
                    n_fail++;
                    $display("FAIL rd_beat_stall beat=%0d: got rvalid=%b rdata=%h rready_fwd=%b, expected 1 %h 0",
                             b, in_rvalid, in_rdata, c ? clint_rready : soc_rready, td[b]);
                end
                @(posedge clk); #1;
            end
            in_rready = 1;
            @(negedge clk);
            n_checks++;
            if ({in_rvalid, in_rdata, in_rlast, in_rid, in_rresp, c ? clint_rready : soc_rready,
                 c ? soc_rready : clint_rready, c ? soc_arvalid : clint_arvalid} !==
                {1'b1, td[b], last, c ? ~id : id, 2'b00, 1'b1, 1'b0, 1'b0}) begin
                n_fail++;
                $display("FAIL rd_beat addr=%h beat=%0d: got rvalid=%b rdata=%h rlast=%b rid=%h rresp=%b, expected 1 %h %b %h 00",
                         addr, b, in_rvalid, in_rdata, in_rlast, in_rid, in_rresp, td[b], last, c ? ~id : id);
            end
            @(posedge clk); #1;
        end
        clear_read();
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [3:0] id, input logic [31:0] data,
                            input logic [3:0] strb);
        logic c;
        c = exp_clint(addr);
        in_awvalid = 1; in_awaddr = addr; in_awid = id; in_awlen = 0; in_awsize = 3'd2; in_awburst = 2'b01;
        in_wvalid = 1; in_wdata = data; in_wstrb = strb; in_wlast = 1; in_bready = 0;
        soc_awready = 1; soc_wready = 1; clint_awready = 1; clint_wready = 1;
        @(negedge clk);
        n_checks++;
        if ({soc_awvalid, clint_awvalid, soc_wvalid, clint_wvalid, in_awready, in_wready} !== 6'b0) begin
            n_fail++;
            $display("FAIL wr_decode_cycle addr=%h: got aw/w handshake bits=%b, expected 000000", addr,
                     {soc_awvalid, clint_awvalid, soc_wvalid, clint_wvalid, in_awready, in_wready});
        end
        @(posedge clk); #1;
        @(negedge clk);
        n_checks++;
        if ({c ? clint_awvalid : soc_awvalid, c ? soc_awvalid : clint_awvalid,
             c ? clint_wvalid : soc_wvalid, c ? soc_wvalid : clint_wvalid, in_awready, in_wready,
             soc_arvalid, clint_arvalid, in_arready,
             c ? clint_awaddr : soc_awaddr, c ? clint_awid : soc_awid, c ? clint_awlen : soc_awlen,
             c ? clint_awsize : soc_awsize, c ? clint_awburst : soc_awburst,
             c ? clint_wdata : soc_wdata, c ? clint_wstrb : soc_wstrb, c ? clint_wlast : soc_wlast} !==
            {9'b101011000, addr, id, 8'd0, 3'd2, 2'b01, data, strb, 1'b1}) begin
            n_fail++;
            $display("FAIL wr_aw_w_forward addr=%h to_clint=%b: got soc_awvalid=%b clint_awvalid=%b soc_wdata=%h clint_wdata=%h arvalid=%b%b",
                     addr, c, soc_awvalid, clint_awvalid, soc_wdata, clint_wdata, soc_arvalid, clint_arvalid);
        end
        @(posedge clk); #1;
        in_awvalid = 0; in_wvalid = 0;
        soc_awready = 0; soc_wready = 0; clint_awready = 0; clint_wready = 0;
        soc_bvalid = 1; clint_bvalid = 1; soc_bid = id; clint_bid = ~id;
        soc_bresp = c ? 2'b10 : 2'b00; clint_bresp = c ? 2'b00 : 2'b10;
        @(negedge clk);
        n_checks++;
        if ({in_bvalid, c ? clint_bready : soc_bready} !== 2'b10) begin
            n_fail++;
            $display("FAIL wr_b_stall addr=%h: got bvalid=%b bready_fwd=%b, expected 1 0", addr, in_bvalid,
                     c ? clint_bready : soc_bready);
        end
        @(posedge clk); #1;
        in_bready = 1;
        @(negedge clk);
        n_checks++;
        if ({in_bvalid, in_bresp, in_bid, c ? clint_bready : soc_bready, c ? soc_bready : clint_bready} !==
            {1'b1, 2'b00, c ? ~id : id, 2'b10}) begin
            n_fail++;
            $display("FAIL wr_b_forward addr=%h: got bvalid=%b bresp=%b bid=%h, expected 1 00 %h",
                     addr, in_bvalid, in_bresp, in_bid, c ? ~id : id);
        end
        @(posedge clk); #1;
        clear_write();
    endtask

    task automatic test_reset();
        clear_write(); clear_read();
        rst = 1;
        in_awvalid = 1; in_awaddr = 32'h8000_0000; in_arvalid = 1; in_araddr = CLINT_BASE;
        in_bready = 1; in_rready = 1; soc_bvalid = 1; soc_rvalid = 1; clint_bvalid = 1; clint_rvalid = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({hs_all, soc_awaddr, soc_araddr, clint_araddr, in_rdata} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got handshakes=%b soc_awaddr=%h soc_araddr=%h, expected all 0",
                     hs_all, soc_awaddr, soc_araddr);
        end
        clear_write(); clear_read();
        @(posedge clk); #1;
        rst = 0;
        @(negedge clk);
        n_checks++;
        if (hs_all !== 15'b0) begin
            n_fail++;
            $display("FAIL reset_release_idle: got handshakes=%b, expected 0", hs_all);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_simultaneous();
        in_arvalid = 1; in_araddr = 32'h0200_0000; in_arid = 4'h5; in_arlen = 0; in_arsize = 3'd2; in_arburst = 2'b01;
        do_write(32'h8000_0010, 4'h2, 32'h1122_3344, 4'hF);
        do_read(32'h0200_0000, 4'h5, 8'd0, -1, 32'hCAFE_F00D);
    endtask

    task automatic test_reset_mid_burst();
        in_arvalid = 1; in_araddr = 32'h8000_0100; in_arid = 4'h3; in_arlen = 8'd3; in_arsize = 3'd2; in_arburst = 2'b01;
        soc_arready = 1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        in_arvalid = 0; soc_arready = 0;
        soc_rvalid = 1; soc_rdata = 32'h0000_0001; soc_rlast = 0; in_rready = 1;
        @(posedge clk); #1;
        soc_rdata = 32'h0000_0002; rst = 1;
        @(negedge clk);
        n_checks++;
        if ({in_rvalid, in_rdata} !== {1'b1, 32'h0000_0002}) begin
            n_fail++;
            $display("FAIL reset_mid_burst_beat2: got rvalid=%b rdata=%h, expected 1 00000002", in_rvalid, in_rdata);
        end
        @(posedge clk); #1;
        @(negedge clk);
        n_checks++;
        if ({hs_all, in_rdata} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_burst_idle: got handshakes=%b rdata=%h, expected 0", hs_all, in_rdata);
        end
        rst = 0;
        clear_read();
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back_random();
        logic [31:0] a;
        logic [7:0]  l;
        for (int t = 0; t < 30; t++) begin
            a = ($urandom_range(0, 1) == 1) ? (CLINT_BASE | ($urandom & 32'h0000_FFFC))
                                            : (32'h8000_0000 | ($urandom & 32'h7FFF_FFFC));
            if ($urandom_range(0, 1) == 1) begin
                do_write(a, 4'($urandom), $urandom, 4'($urandom_range(1, 15)));
            end else begin
                l = 8'($urandom_range(0, 3));
                do_read(a, 4'($urandom), l, $urandom_range(0, int'(l) + 1), $urandom);
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        do_read(32'h8000_0000, 4'h1, 8'd0, -1, 32'hDEAD_BEEF);     // read SoC
        do_read(32'h0200_BFF8, 4'h4, 8'd0, -1, 32'h0000_1234);     // read CLINT
        do_write(32'hA000_03F8, 4'h6, 32'h0000_0041, 4'h1);        // write SoC
        test_simultaneous();
        do_read(32'h8000_0040, 4'h7, 8'd3, 1, 32'h0BAD_CAFE);      // burst with beat-2 stall
        do_read(32'h0200_FFFC, 4'h8, 8'd0, -1, 32'h0000_00AA);     // decode boundaries
        do_read(32'h0201_0000, 4'h9, 8'd0, -1, 32'h0000_00BB);
        do_read(32'h01FF_FFFC, 4'hA, 8'd0, -1, 32'h0000_00CC);
        do_write(32'h0200_4000, 4'hB, 32'h5555_AAAA, 4'hF);
        test_back_to_back_random();
        test_reset_mid_burst();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ysyx_24090012_xbar.md
# ysyx_24090012_xbar

Two-target AXI4 crossbar between the memory arbiter's single master port and the system's slaves. It decodes each transaction's address and routes the whole transaction to one of two targets: the core-local CLINT timer or the SoC bus (`soc_*`). All response channels pass straight through with no added latency. Only one transaction is in flight at a time, matching the arbiter's one-owner-at-a-time policy.

## Interface
- `CLINT_BASE`, default 32'h0200_0000: CLINT region base address.
- `CLINT_MASK`, default 32'hFFFF_0000: an address hits the CLINT when `(addr & CLINT_MASK) == CLINT_BASE`.
- `clk` in 1: clock.
- `rst` in 1: synchronous, active-high reset.
- `in_aw{valid,ready,addr,id,len,size,burst}` in/out/in… 1,1,32,4,8,3,2: write-address channel from the arbiter; `ready` is the output.
- `in_w{valid,ready,data,strb,last}` 1,1,32,4,1: write-data channel from the arbiter; `ready` is the output.
- `in_b{ready,valid,resp,id}` 1,1,2,4: write-response channel to the arbiter; `valid`, `resp` and `id` are outputs.
- `in_ar{valid,ready,addr,id,len,size,burst}` 1,1,32,4,8,3,2: read-address channel from the arbiter; `ready` is the output.
- `in_r{ready,valid,resp,data,last,id}` 1,1,2,32,1,4: read-data channel to the arbiter; `ready` is the input.
- `soc_*` (all five channels, same widths, directions mirrored): master port toward the SoC.
- `clint_*` (all five channels, same widths, directions mirrored): master port toward the CLINT.

## Operation
- States: IDLE, WR_SOC, WR_CLINT, RD_SOC, RD_CLINT, held in a registered state variable.
- IDLE:
  - If `in_awvalid`, go to WR_CLINT when `in_awaddr` hits the CLINT region, otherwise WR_SOC.
  - Else if `in_arvalid`, go to RD_CLINT or RD_SOC by the same decode on `in_araddr`.
  - Otherwise stay in IDLE.
  - When AW and AR are valid in the same cycle, the write wins; the read stays pending.
- In IDLE, every valid/ready driven toward either side is 0. No handshake completes in IDLE.
- WR_x state:
  - AW, W and B channels are connected to target x: valids/payload forward, readies return.
  - The other target sees all its valids and readies at 0.
  - Upstream AR/R handshake signals are held at 0.
  - Exit to IDLE on `x_bvalid && in_bready`.
- RD_x state:
  - AR and R channels are connected to target x.
  - Write channels are held at 0.
  - Exit to IDLE on `x_rvalid && in_rready && x_rlast`.
  - Multi-beat bursts (`arlen>0`) stay routed until the last beat.
- Payload outputs (addr, data, resp, id, ...) are muxed from the selected side and are 0 in IDLE.
- The crossbar does not check burst legality toward the CLINT; the CLINT is responsible for that.

## Timing
- Reset: state = IDLE. All `*valid` and `*ready` outputs are 0 in the cycle after `rst` is sampled high.
- Reset mid-transaction: the transaction is abandoned and both targets see their valids drop on the next edge. The arbiter is reset on the same signal.
- Address path latency: 1 cycle of decode. A valid first seen at edge N appears on the target at N+1 and can handshake no earlier than N+1.
- W, B and R paths: 0-cycle combinational passthrough while in the routed state.
- Back-to-back transactions: there is always at least one IDLE cycle between the final B/R handshake and the next AW/AR forward.
- Decode address is sampled only in IDLE. The upstream master holds addr stable while valid, per AXI.

## Configuration
- `XBAR_CLINT_EN` defined: two targets, decoded as above.
- `XBAR_CLINT_EN` undefined:
  - Every address routes to SoC; WR_CLINT and RD_CLINT are never entered.
  - `clint_*` outputs are tied to 0; `clint_*` inputs are ignored.
  - The 1-cycle address decode latency is retained, so timing is identical to the enabled build.

## Test plan
- Read SoC: AR addr 0x8000_0000, len 0; SoC returns rdata 0xDEAD_BEEF with rlast=1. Expect AR on `soc_*` one cycle after `in_arvalid`, `in_rdata`=0xDEAD_BEEF, state back to IDLE, and no `clint_arvalid` at any point.
- Read CLINT: AR addr 0x0200_BFF8; CLINT returns 0x0000_1234. Expect `clint_arvalid` asserted and `in_rdata`=0x0000_1234. With `XBAR_CLINT_EN` undefined, the same AR goes to `soc_*` instead.
- Write SoC: AW addr 0xA000_03F8 with W data 0x41, strb 0x1, wlast=1. Expect `soc_wdata`=0x41, B forwarded with bresp 0, and exit to IDLE on the B handshake.
- Simultaneous: AW to 0x8000_0010 and AR to 0x0200_0000 asserted in the same cycle. Expect WR_SOC first. Only after the B handshake plus one IDLE cycle does the read go to the CLINT.
- Burst: AR len 3 to SoC, with `in_rready` low on beat 2. Expect all 4 beats forwarded in order, the beat-2 stall honoured, and IDLE only after beat 4 (rlast).
- Reset mid-burst: assert `rst` during beat 2 of a len-3 read. Expect all valids/readies 0 the next cycle and state IDLE.
